pipe_ctrl_chain: RTL and testbench

PIPE_CTRL_CHAIN -- requirements
Module: pipe_ctrl_chain

---
 rtl/pipe_ctrl_chain.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl_chain.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: a chain of control-bundle pipeline registers (ID/EX, EX/MEM, MEM/WB by default).
// Each stage can be held or flushed. The hold of an older stage also freezes every younger stage.
// A stage whose upstream neighbour is frozen is loaded with a bubble.
//
// Ports:
//   clk, R          single clock; asynchronous active-low reset
//   in_ctrl/in_valid control bundle and valid bit from the decode mux
//   nop_sel         forces a bubble into stage 0
//   hold, flush     per-stage hold and kill requests (bit i = stage i); flush wins over hold
//   clr_cnt         synchronous clear of stall_cycles
//   stage_ctrl      stage i bundle at [i*WIDTH +: WIDTH]
//   stage_valid     per-stage valid
//   in_ready        stage 0 accepts input this cycle (combinational)
//   occupancy       number of valid stages (combinational)
//   stall_cycles    saturating count of cycles with in_ready=0

// One pipeline register for a valid bit and a control bundle.
module pipe_ctrl_stage #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             hold,
  input  logic             bubble,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] ctrl_in,
  output logic             vld_q,
  output logic [WIDTH-1:0] ctrl_q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
    end else if (flush) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
    end else if (hold) begin
      vld_q  <= vld_q;
      ctrl_q <= ctrl_q;
    end else if (bubble || !vld_in) begin
      // An invalid stage always carries an all-zero bundle, so no enable leaks downstream.
      vld_q  <= 1'b0;
      ctrl_q <= '0;
    end else begin
      vld_q  <= 1'b1;
      ctrl_q <= ctrl_in;
    end
  end
endmodule

module pipe_ctrl_chain #(
  parameter int WIDTH  = 13,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    R,
  input  logic [WIDTH-1:0]        in_ctrl,
  input  logic                    in_valid,
  input  logic                    nop_sel,
  input  logic [STAGES-1:0]       hold,
  input  logic [STAGES-1:0]       flush,
  input  logic                    clr_cnt,
  output logic [STAGES*WIDTH-1:0] stage_ctrl,
  output logic [STAGES-1:0]       stage_valid,
  output logic                    in_ready,
  output logic [OCC_W-1:0]        occupancy,
  output logic [CNT_W-1:0]        stall_cycles
);
  // Index 0 is the bundle offered at the input. Index i+1 is the output of stage i.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] ctrl_pipe;
  logic [STAGES-1:0]          eh;
  logic [CNT_W-1:0]           stall_q;
  logic [OCC_W-1:0]           occ;

  assign vld_pipe[0]  = in_valid & ~nop_sel;
  assign ctrl_pipe[0] = in_ctrl;

  // Effective hold: a held stage also freezes every younger stage behind it.
  always_comb begin
    eh = '0;
    eh[STAGES-1] = hold[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) eh[i] = hold[i] | eh[i+1];
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             bub;
    logic             vin;
    logic [WIDTH-1:0] cin;
    if (i == 0) begin : g_head
      assign bub = 1'b0;
      assign vin = vld_pipe[0];
      assign cin = ctrl_pipe[0];
    end else begin : g_body
      // If the upstream stage is frozen, this stage takes a bubble.
      // If the upstream stage is being flushed, what it hands down is killed.
      assign bub = eh[i-1];
      assign vin = vld_pipe[i] & ~flush[i-1];
      assign cin = ctrl_pipe[i];
    end
    pipe_ctrl_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst_n  (R),
      .flush  (flush[i]),
      .hold   (eh[i]),
      .bubble (bub),
      .vld_in (vin),
      .ctrl_in(cin),
      .vld_q  (vld_pipe[i+1]),
      .ctrl_q (ctrl_pipe[i+1])
    );
  end

  assign stage_valid = vld_pipe[STAGES:1];
  assign stage_ctrl  = ctrl_pipe[STAGES:1];
  assign in_ready    = ~eh[0];

  always_comb begin
    occ = '0;
    for (int i = 1; i <= STAGES; i++) occ = occ + OCC_W'(vld_pipe[i]);
  end
  assign occupancy = occ;

  always_ff @(posedge clk or negedge R) begin
    if (!R)                         stall_q <= '0;
    else if (clr_cnt)               stall_q <= '0;
    else if (!in_ready && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
  end
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
module tb_pipe_ctrl_chain;
  localparam int W = 13;
  localparam int S = 3;

  logic          clk = 1'b0;
  logic          R;
  logic [W-1:0]  in_ctrl;
  logic          in_valid, nop_sel, clr_cnt;
  logic [S-1:0]  hold, flush;
  logic [S*W-1:0] stage_ctrl, stage_ctrl4;
  logic [S-1:0]  stage_valid, stage_valid4;
  logic          in_ready, in_ready4;
  logic [1:0]    occupancy, occupancy4;
  logic [15:0]   stall_cycles;
  logic [3:0]    stall_cycles4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_chain dut (
    .clk(clk), .R(R), .in_ctrl(in_ctrl), .in_valid(in_valid), .nop_sel(nop_sel),
    .hold(hold), .flush(flush), .clr_cnt(clr_cnt), .stage_ctrl(stage_ctrl),
    .stage_valid(stage_valid), .in_ready(in_ready), .occupancy(occupancy),
    .stall_cycles(stall_cycles)
  );

  pipe_ctrl_chain #(.CNT_W(4)) dut4 (
    .clk(clk), .R(R), .in_ctrl(in_ctrl), .in_valid(in_valid), .nop_sel(nop_sel),
    .hold(hold), .flush(flush), .clr_cnt(clr_cnt), .stage_ctrl(stage_ctrl4),
    .stage_valid(stage_valid4), .in_ready(in_ready4), .occupancy(occupancy4),
    .stall_cycles(stall_cycles4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] sc(input int i);
    return stage_ctrl[i*W +: W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    R = 1'b0; in_ctrl = '0; in_valid = 1'b0; nop_sel = 1'b0;
    hold = '0; flush = '0; clr_cnt = 1'b0;
    #2;
    check("rst_valid", 64'(stage_valid), 64'(0));
    check("rst_ctrl", 64'(stage_ctrl), 64'(0));
    check("rst_stall", 64'(stall_cycles), 64'(0));
    check("rst_occ", 64'(occupancy), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(1));
    #1;
    R = 1'b1; in_valid = 1'b1; in_ctrl = 13'h0A1;
    step();
    check("lat_s0_e1", 64'(sc(0)), 64'(13'h0A1));
    check("lat_v_e1", 64'(stage_valid), 64'(3'b001));
    in_ctrl = 13'h0B2;
    step();
    in_ctrl = 13'h0C3;
    step();
    check("flow_s2", 64'(sc(2)), 64'(13'h0A1));
    check("flow_s1", 64'(sc(1)), 64'(13'h0B2));
    check("flow_s0", 64'(sc(0)), 64'(13'h0C3));
    check("flow_occ", 64'(occupancy), 64'(3));
    check("flow_stall", 64'(stall_cycles), 64'(0));

    // Stage 1 is held: stages 0 and 1 freeze and stage 2 takes bubbles.
    in_ctrl = 13'h0D4; hold = 3'b010;
    #1;
    check("stall_ready_comb", 64'(in_ready), 64'(0));
    step();
    step();
    check("stall_s0", 64'(sc(0)), 64'(13'h0C3));
    check("stall_s1", 64'(sc(1)), 64'(13'h0B2));
    check("stall_s2_ctrl", 64'(sc(2)), 64'(0));
    check("stall_valid", 64'(stage_valid), 64'(3'b011));
    check("stall_cnt", 64'(stall_cycles), 64'(2));
    check("stall_occ", 64'(occupancy), 64'(2));

    // Reset is asserted between edges while the stall is in progress.
    #2;
    R = 1'b0;
    #1;
    check("arst_valid", 64'(stage_valid), 64'(0));
    check("arst_ctrl", 64'(stage_ctrl), 64'(0));
    check("arst_stall", 64'(stall_cycles), 64'(0));
    check("arst_occ", 64'(occupancy), 64'(0));
    check("arst_ready", 64'(in_ready), 64'(0));
    hold = '0; in_valid = 1'b0;
    #1;
    R = 1'b1;

    // Flush and hold on stage 0 in the same cycle.
    in_valid = 1'b1; in_ctrl = 13'h111;
    step();
    in_ctrl = 13'h222;
    step();
    in_ctrl = 13'h333; hold = 3'b001; flush = 3'b001;
    #1;
    check("fp_ready", 64'(in_ready), 64'(0));
    step();
    check("fp_valid", 64'(stage_valid), 64'(3'b100));
    check("fp_s0", 64'(sc(0)), 64'(0));
    check("fp_s1", 64'(sc(1)), 64'(0));
    check("fp_s2", 64'(sc(2)), 64'(13'h111));
    hold = '0; flush = '0;

    // Flushing stage 1 kills the stage 1 contents that would otherwise be handed down to stage 2.
    in_ctrl = 13'h444;
    step();
    in_ctrl = 13'h555;
    step();
    check("fm_pre_s1", 64'(sc(1)), 64'(13'h444));
    in_valid = 1'b0; flush = 3'b010;
    step();
    check("fm_valid", 64'(stage_valid), 64'(0));
    check("fm_ctrl", 64'(stage_ctrl), 64'(0));
    flush = '0;

    // nop_sel forces bubbles even when a valid input is offered.
    in_valid = 1'b1; in_ctrl = 13'h1FFF; nop_sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("nop_valid", 64'(stage_valid), 64'(0));
      check("nop_ctrl", 64'(stage_ctrl), 64'(0));
    end
    nop_sel = 1'b0; in_valid = 1'b0;

    // Counter saturation (4-bit instance) and clear.
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("cnt_clr0", 64'(stall_cycles), 64'(0));
    hold = 3'b001;
    for (int k = 0; k < 20; k++) step();
    check("cnt_sat4", 64'(stall_cycles4), 64'(15));
    check("cnt_wide", 64'(stall_cycles), 64'(20));
    clr_cnt = 1'b1;
    step();
    check("cnt_clr_hold4", 64'(stall_cycles4), 64'(0));
    check("cnt_clr_hold", 64'(stall_cycles), 64'(0));
    clr_cnt = 1'b0;
    step();
    check("cnt_resume", 64'(stall_cycles), 64'(1));
    hold = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
